// File: rtl/sdp_ram_pkg.sv
// Shared constants and lane helpers for the byte-enable simple dual-port RAM.
// The helpers work on a maximum-width container; callers size-cast in and out.
package sdp_ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  localparam int MAX_W  = 512;
  localparam int MAX_NB = 64;

  // Per-lane select: lanes whose enable is set take new_word, others keep old_word.
  function automatic logic [MAX_W-1:0] lane_merge(
    input logic [MAX_W-1:0]  old_word,
    input logic [MAX_W-1:0]  new_word,
    input logic [MAX_NB-1:0] be,
    input int                width,
    input int                byte_w
  );
    logic [MAX_W-1:0]  r;
    logic [MAX_NB-1:0] sel;
    r = old_word;
    for (int b = 0; b < width; b++) begin
      sel = be >> (b / byte_w);
      if (sel[0]) begin
        r[b] = new_word[b];
      end
    end
    return r;
  endfunction

  // Even parity per lane: each returned bit is the XOR of its lane's data bits.
  function automatic logic [MAX_NB-1:0] lane_parity(
    input logic [MAX_W-1:0] word,
    input int               width,
    input int               byte_w
  );
    logic [MAX_NB-1:0] p;
    p = '0;
    for (int b = 0; b < width; b++) begin
      p = p ^ (MAX_NB'(word[b]) << (b / byte_w));
    end
    return p;
  endfunction

endpackage

// File: rtl/sdp_ram_out_stage.sv
// Optional output register for read data, valid and parity error.
// OUT_REG=0 makes this a wire-through; OUT_REG=1 adds one cycle of latency.
module sdp_ram_out_stage #(
  parameter int WIDTH   = 32,
  parameter int OUT_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_perr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             perr
);

  generate
    if (OUT_REG != 0) begin : g_reg
      // Data and parity only move with a valid word so dout holds between reads.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data  <= '0;
          valid <= 1'b0;
          perr  <= 1'b0;
        end else begin
          valid <= in_valid;
          if (in_valid) begin
            data <= in_data;
            perr <= in_perr;
          end
        end
      end
    end else begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign data  = in_data;
      assign valid = in_valid;
      assign perr  = in_perr;
    end
  endgenerate

endmodule

// File: rtl/sdp_ram_be_pipe.sv
// Simple dual-port RAM with byte-lane write enables, selectable read-during-write
// and optional output register. Macro SDP_RAM_PARITY_EN adds per-lane even parity.
//
// Read handshake: rd_en is a strobe with no backpressure; every rd_en accepted on
// an edge with rst=0 yields exactly one dout_valid pulse after 1 (OUT_REG=0) or
// 2 (OUT_REG=1) edges, unless rst intervenes, which drops it.
module sdp_ram_be_pipe
  import sdp_ram_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 16,
  parameter  int BYTE_W   = 8,
  parameter  int OUT_REG  = 0,
  parameter  int RDW_MODE = 0,
  localparam int NB       = WIDTH / BYTE_W,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [NB-1:0]    wr_be,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             parity_err
);

  localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_ok;
  logic             rd_ok;
  logic             fwd;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_word;
  logic [WIDTH-1:0] rd_word;
  logic             rd_perr;

  logic [WIDTH-1:0] s0_data;
  logic             s0_valid;
  logic             s0_perr;

  // DEPTH need not be a power of two, so addresses are range-checked explicitly.
  assign wr_ok  = wr_en && ({1'b0, wr_addr} < DEPTH_LIM);
  assign rd_ok  = {1'b0, rd_addr} < DEPTH_LIM;
  assign fwd    = (RDW_MODE == RDW_WRITE_FIRST) && wr_ok && rd_en && (wr_addr == rd_addr);
  assign wr_old = mem[wr_addr];

  assign wr_word = WIDTH'(lane_merge(MAX_W'(wr_old), MAX_W'(din), MAX_NB'(wr_be),
                                     WIDTH, BYTE_W));

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_addr] <= wr_word;
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      rd_word = fwd ? wr_word : mem[rd_addr];
    end
  end

`ifdef SDP_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] din_par;
  logic [NB-1:0] rd_par_calc;

  assign din_par     = NB'(lane_parity(MAX_W'(din), WIDTH, BYTE_W));
  assign rd_par_calc = NB'(lane_parity(MAX_W'(mem[rd_addr]), WIDTH, BYTE_W));

  // Only written lanes take fresh parity; untouched lanes keep what they stored.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      par_mem[wr_addr] <= (par_mem[wr_addr] & ~wr_be) | (din_par & wr_be);
    end
  end

  // Forwarded data was just computed from din, so it cannot carry a mismatch.
  assign rd_perr = rd_ok && !fwd && (|(rd_par_calc ^ par_mem[rd_addr]));
`else
  assign rd_perr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_data  <= '0;
      s0_valid <= 1'b0;
      s0_perr  <= 1'b0;
    end else begin
      s0_valid <= rd_en;
      if (rd_en) begin
        s0_data <= rd_word;
        s0_perr <= rd_perr;
      end
    end
  end

  sdp_ram_out_stage #(
    .WIDTH   (WIDTH),
    .OUT_REG (OUT_REG)
  ) u_out_stage (
    .clk      (clk),
    .rst      (rst),
    .in_data  (s0_data),
    .in_valid (s0_valid),
    .in_perr  (s0_perr),
    .data     (dout),
    .valid    (dout_valid),
    .perr     (parity_err)
  );

endmodule

// File: doc/sdp_ram_be_pipe.md
# sdp_ram_be_pipe

Parametrised simple dual-port RAM, successor to the basic one-write/one-read array:
- Independent write and read ports on one clock.
- Per-byte write enables and an explicit read enable with a valid flag.
- Selectable read-during-write behaviour and an optional output register stage.
- Intended for datapath FIFOs and line buffers that need partial-word updates and a timing-friendly read path.

## Interface
- WIDTH, 32, data width in bits; must be a multiple of BYTE_W.
- DEPTH, 16, number of words; need not be a power of two.
- BYTE_W, 8, bits per write-enable lane; NB = WIDTH/BYTE_W.
- OUT_REG, 0, 0 gives read latency 1; 1 adds an output register for latency 2.
- RDW_MODE, 0, 0 = read-first (old data on same-address collision), 1 = write-first (new merged data).
- clk, input, 1, single clock; all logic on rising edge.
- rst, input, 1, reset; asynchronous, active-high.
- wr_en, input, 1, write strobe.
- wr_be, input, NB, byte-lane enables; lane i covers din[i*BYTE_W +: BYTE_W].
- wr_addr, input, $clog2(DEPTH), write address.
- din, input, WIDTH, write data.
- rd_en, input, 1, read strobe.
- rd_addr, input, $clog2(DEPTH), read address.
- dout, output, WIDTH, read data; holds its last value when no new read completes.
- dout_valid, output, 1, one-cycle pulse marking a new dout.
- parity_err, output, 1, parity mismatch on the word presented with dout_valid (see Configuration).

## Operation
- Write: on a clk edge with wr_en=1 and wr_addr<DEPTH, update only the lanes with wr_be[i]=1. If wr_be is all zero, nothing changes.
- Read: on a clk edge with rd_en=1, capture mem[rd_addr] into the read stage.
- Out-of-range addresses (addr>=DEPTH):
  - write is ignored;
  - read returns all zeros with dout_valid asserted and parity_err=0.
- Collision: wr_en=1, rd_en=1 and wr_addr==rd_addr on the same edge.
  - RDW_MODE=0: dout is the pre-write word.
  - RDW_MODE=1: dout is the merge, per lane, of din where wr_be=1 and the old word otherwise.
- Back-to-back reads at one per cycle are supported at both latencies.
- Reset:
  - dout=0, dout_valid=0, parity_err=0, and all pipeline valids cleared.
  - Memory contents are not reset and are undefined after power-up.
- While rst=1, wr_en and rd_en are ignored.
- Reset asserted mid-operation drops any in-flight read; no dout_valid is produced for it.

## Timing
- OUT_REG=0: rd_en sampled at edge N gives dout and dout_valid=1 after edge N, for one cycle unless rd_en is held.
- OUT_REG=1: the same read appears after edge N+1. The stage-1 valid propagates to dout_valid.
- A write at edge N is visible to a non-colliding read sampled at edge N+1 or later.
- rst deassertion is synchronised externally. The first accepted strobe is on the first edge with rst=0.

## Configuration
- Macro SDP_RAM_PARITY_EN.
- Defined:
  - Each lane stores one extra even-parity bit, computed from din at write time.
  - On read, parity is recomputed per lane and compared.
  - parity_err is the OR of lane mismatches, aligned with dout_valid and registered through the OUT_REG stage.
  - Write-first forwarded data carries freshly computed parity.
- Not defined:
  - No parity storage.
  - parity_err is still a port, tied to 0.

## Structure
- Package sdp_ram_pkg holds:
  - localparams RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1;
  - a function for lane merge of old word, din and wr_be;
  - a function for per-lane even parity.
- Sub-module sdp_ram_out_stage:
  - optional register for dout, dout_valid and parity_err with async reset;
  - generated only when OUT_REG=1, otherwise a pass-through.

## Test plan
- Full-word write then read (WIDTH=32, DEPTH=16, OUT_REG=0): write 0xDEADBEEF to addr 3, then rd_en to addr 3 next cycle. Required: dout=0xDEADBEEF with dout_valid=1 exactly one edge after rd_en.
- Byte enables: addr 5 holds 0x11223344; write din=0xAABBCCDD with wr_be=4'b0101. Required: next read of addr 5 returns 0x11BB33DD.
- Collision: addr 7 holds 0x0; same-edge write of 0x12345678 (wr_be=all ones) and read of addr 7.
  - RDW_MODE=0: dout=0x0.
  - RDW_MODE=1: dout=0x12345678.
- Pipeline and reset (OUT_REG=1): reads of addrs 0,1,2 on consecutive edges give three consecutive dout_valid pulses starting two edges after the first rd_en. Asserting rst one cycle after the last rd_en gives dout=0 and dout_valid=0 immediately, with no further pulses.
- Out of range (DEPTH=12): write of 0xFFFFFFFF to addr 13 is ignored; read of addr 13 returns 0 with dout_valid=1. Reads of addrs 0-11 are unchanged.
- Parity (SDP_RAM_PARITY_EN): force-flip one stored data bit at addr 2 via backdoor, then read. Required: parity_err=1 with dout_valid. A clean word gives parity_err=0.
